// File: rtl/write_back.sv
// write_back: final CHIP-8 stage. It commits V0-VF and I, sequences the VF flag write, and tracks burst loads.
// Ports: clk/rst (async active-low). stalled freezes the stage. wb_* is the beat from memory_access. stall holds upstream. rd_* are bypassed reads. i_reg and burst_idx are state outputs. Macro: WB_I_INCREMENT_EN.
module write_back (
  input  logic        clk,
  input  logic        rst,
  input  logic        stalled,
  input  logic        wb_valid,
  input  logic [1:0]  wb_op,
  input  logic [3:0]  wb_x,
  input  logic [15:0] wb_data,
  input  logic        wb_flag,
  input  logic        wb_last,
  output logic        stall,
  input  logic [3:0]  rd_x_addr,
  input  logic [3:0]  rd_y_addr,
  output logic [7:0]  rd_x_data,
  output logic [7:0]  rd_y_data,
  output logic [15:0] i_reg,
  output logic [3:0]  burst_idx
);

  typedef enum logic {IDLE, FLAG} state_t;

  state_t      state_q, state_d;
  logic [7:0]  v_q [16];
  logic [15:0] i_q, i_d;
  logic [3:0]  bidx_q, bidx_d;
  logic        flag_q, flag_d;

  logic        accept;
  logic        wen;
  logic [3:0]  waddr;
  logic [7:0]  wdata;

  assign accept = (state_q == IDLE) && wb_valid && !stalled;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    bidx_d  = bidx_q;
    flag_d  = flag_q;
    wen     = 1'b0;
    waddr   = wb_x;
    wdata   = wb_data[7:0];
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (wb_op == 2'd0): begin
              wen    = 1'b1;
              bidx_d = '0;
            end
            (wb_op == 2'd1): begin
              i_d    = wb_data;
              bidx_d = '0;
            end
            (wb_op == 2'd2): begin
              wen     = 1'b1;
              bidx_d  = '0;
              flag_d  = wb_flag;
              state_d = FLAG;
            end
            (wb_op == 2'd3): begin
              wen   = 1'b1;
              waddr = bidx_q;
              if (wb_last) begin
                bidx_d = '0;
`ifdef WB_I_INCREMENT_EN
                i_d = i_q + 16'(bidx_q) + 16'd1;
`endif
              end else begin
                bidx_d = bidx_q + 4'd1;
              end
            end
          endcase
        end
      end
      FLAG: begin
        // The VF write lands after the Vx write, so the flag wins when x is F.
        if (!stalled) begin
          wen     = 1'b1;
          waddr   = 4'hF;
          wdata   = {7'b0, flag_q};
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      bidx_q  <= '0;
      flag_q  <= 1'b0;
      for (int k = 0; k < 16; k++) v_q[k] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      bidx_q  <= bidx_d;
      flag_q  <= flag_d;
      if (wen) v_q[waddr] <= wdata;
    end
  end

  assign rd_x_data = (wen && rd_x_addr == waddr) ? wdata : v_q[rd_x_addr];
  assign rd_y_data = (wen && rd_y_addr == waddr) ? wdata : v_q[rd_y_addr];

  assign stall     = (state_q == FLAG);
  assign i_reg     = i_q;
  assign burst_idx = bidx_q;

endmodule

// File: tb/tb_write_back.sv
// tb_write_back: randomized plus directed scoreboard bench for write_back.
// A reference model predicts each cycle's outputs, and a monitor compares them at the falling edge.
module tb_write_back;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stalled = 1'b0;
  logic        wb_valid = 1'b0;
  logic [1:0]  wb_op = '0;
  logic [3:0]  wb_x = '0;
  logic [15:0] wb_data = '0;
  logic        wb_flag = 1'b0;
  logic        wb_last = 1'b0;
  logic [3:0]  rd_x_addr = '0;
  logic [3:0]  rd_y_addr = '0;
  logic        stall;
  logic [7:0]  rd_x_data, rd_y_data;
  logic [15:0] i_reg;
  logic [3:0]  burst_idx;

  write_back dut (
    .clk(clk), .rst(rst), .stalled(stalled),
    .wb_valid(wb_valid), .wb_op(wb_op), .wb_x(wb_x),
    .wb_data(wb_data), .wb_flag(wb_flag), .wb_last(wb_last),
    .stall(stall),
    .rd_x_addr(rd_x_addr), .rd_y_addr(rd_y_addr),
    .rd_x_data(rd_x_data), .rd_y_data(rd_y_data),
    .i_reg(i_reg), .burst_idx(burst_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [7:0]  rx;
    logic [7:0]  ry;
    logic [15:0] i;
    logic [3:0]  b;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  int m_v[16];
  int m_i, m_b, m_pf;
  bit m_pend;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_v[k] = 0;
    m_i = 0;
    m_b = 0;
    m_pf = 0;
    m_pend = 1'b0;
  endtask

  // One cycle: drive inputs, predict this cycle's outputs, advance the model.
  task automatic cyc(input bit v, input int op, input int x, input int d,
                     input int f, input int l, input int s,
                     input int ra, input int rb);
    exp_t e;
    @(posedge clk);
    #1;
    wb_valid  = v;
    wb_op     = 2'(op);
    wb_x      = 4'(x);
    wb_data   = 16'(d);
    wb_flag   = 1'(f);
    wb_last   = 1'(l);
    stalled   = 1'(s);
    rd_x_addr = 4'(ra);
    rd_y_addr = 4'(rb);
    e.st = m_pend;
    e.i  = 16'(m_i);
    e.b  = 4'(m_b);
    if (s == 0) begin
      if (m_pend) begin
        m_v[15] = m_pf;
        m_pend = 1'b0;
      end else if (v) begin
        case (op)
          0: begin m_v[x] = d % 256; m_b = 0; end
          1: begin m_i = d % 65536; m_b = 0; end
          2: begin m_v[x] = d % 256; m_pf = f; m_pend = 1'b1; m_b = 0; end
          default: begin
            m_v[m_b] = d % 256;
            if (l != 0) begin
`ifdef WB_I_INCREMENT_EN
              m_i = (m_i + m_b + 1) % 65536;
`endif
              m_b = 0;
            end else begin
              m_b = (m_b + 1) % 16;
            end
          end
        endcase
      end
    end
    // The read ports show the value each register holds after this cycle's write.
    e.rx = 8'(m_v[ra]);
    e.ry = 8'(m_v[rb]);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", {15'b0, stall}, {15'b0, e.st});
      chk("rd_x", {8'b0, rd_x_data}, {8'b0, e.rx});
      chk("rd_y", {8'b0, rd_y_data}, {8'b0, e.ry});
      chk("i_reg", i_reg, e.i);
      chk("burst_idx", {12'b0, burst_idx}, {12'b0, e.b});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 15);
    cyc(1, 0, 3, 'h00AB, 0, 0, 0, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 3, 3);

    cyc(1, 2, 5, 'h00FF, 1, 0, 0, 5, 15);
    cyc(0, 0, 0, 0, 0, 0, 0, 15, 5);
    cyc(0, 0, 0, 0, 0, 0, 0, 15, 5);
    cyc(1, 2, 15, 'h0077, 0, 0, 0, 15, 5);
    cyc(0, 0, 0, 0, 0, 0, 0, 15, 14);
    cyc(0, 0, 0, 0, 0, 0, 0, 15, 14);

    cyc(1, 1, 0, 'h0300, 0, 0, 0, 0, 1);
    cyc(1, 3, 0, 'h11, 0, 0, 0, 0, 1);
    cyc(1, 3, 0, 'h22, 0, 0, 0, 1, 2);
    cyc(1, 3, 0, 'h33, 0, 0, 0, 2, 3);
    cyc(1, 3, 0, 'h44, 0, 1, 0, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 2, 3);

    cyc(1, 3, 0, 'hA1, 0, 0, 0, 0, 1);
    cyc(1, 3, 0, 'hA2, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 'h0FFE, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);

    cyc(1, 2, 7, 'h5A, 1, 0, 0, 7, 15);
    for (int k = 0; k < 3; k++) cyc(1, 0, 2, 'h99, 0, 0, 1, 15, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 15, 7);
    cyc(0, 0, 0, 0, 0, 0, 0, 15, 2);

    for (int n = 0; n < 400; n++)
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
          int'($urandom_range(0, 1)), int'($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 2, 5, 'h3C, 1, 0, 0, 5, 15);
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    stalled = 1'b0;
    chk("flag_stall", {15'b0, stall}, 16'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_stall", {15'b0, stall}, 16'd0);
    for (int k = 0; k < 16; k++) begin
      rd_x_addr = 4'(k);
      rd_y_addr = 4'(15 - k);
      #1;
      chk("rst_vx", {8'b0, rd_x_data}, 16'd0);
    end
    chk("rst_i", i_reg, 16'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 15, 5);
    cyc(1, 0, 9, 'h42, 0, 0, 0, 9, 15);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
